// File: rtl/dnn2ami_pkg.sv
// rtl/dnn2ami_pkg.sv - shared types, constants and length helper for the dnn2ami write path
package dnn2ami_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        CMD  = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int LINE_BYTES = 64;
    localparam int PAGE_BYTES = 4096;
    localparam int LINE_SHIFT = 6;

    // Smallest of three unsigned quantities; used to clip a command length.
    function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
        logic [31:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/dnn2ami_rr_arbiter.sv
// rtl/dnn2ami_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module dnn2ami_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // First requester found walking upward from ptr, wrapping at N.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/dnn2ami_wr_sched.sv
// rtl/dnn2ami_wr_sched.sv - PU-to-AMI write scheduler: arbitrate, split into page-safe bursts, sequence beats
module dnn2ami_wr_sched
    import dnn2ami_pkg::*;
#(
    parameter int NUM_PU    = 2,
    parameter int ADDR_W    = 64,
    parameter int SIZE_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int LEN_W     = $clog2(MAX_BURST) + 1,
    parameter int SRC_W     = (NUM_PU > 1) ? $clog2(NUM_PU) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_PU-1:0]        pu_wr_req,
    input  logic [NUM_PU*ADDR_W-1:0] pu_wr_addr,
    input  logic [NUM_PU*SIZE_W-1:0] pu_wr_size,
    output logic [NUM_PU-1:0]        pu_wr_grant,
    output logic [NUM_PU-1:0]        pu_wr_done,
    input  logic [NUM_PU-1:0]        outbuf_valid,
    output logic [NUM_PU-1:0]        outbuf_pop,
    output logic                     ami_cmd_valid,
    input  logic                     ami_cmd_ready,
    output logic [ADDR_W-1:0]        ami_cmd_addr,
    output logic [LEN_W-1:0]         ami_cmd_len,
    output logic                     ami_wr_valid,
    input  logic                     ami_wr_ready,
    output logic [SRC_W-1:0]         ami_wr_src,
    output logic                     ami_wr_last,
    output logic                     busy
);

    state_t              state, state_nxt;
    logic [SRC_W-1:0]    owner, owner_nxt, rr_ptr;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [SIZE_W-1:0]   rem, rem_nxt;
    logic [LEN_W-1:0]    beats, beats_nxt, cmd_len, len_nxt;
    logic [NUM_PU-1:0]   arb_gnt;
    logic [SRC_W-1:0]    arb_idx;
    logic                arb_any;
    logic [ADDR_W-1:0]   sel_addr;
    logic [SIZE_W-1:0]   sel_size;
    logic                beat_hs;
    logic                cmd_valid_q, busy_q;
    logic [NUM_PU-1:0]   grant_q, done_q;

    dnn2ami_rr_arbiter #(.N(NUM_PU), .IW(SRC_W)) u_arb (
        .req (pu_wr_req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign sel_addr = pu_wr_addr[arb_idx*ADDR_W +: ADDR_W];
    assign sel_size = pu_wr_size[arb_idx*SIZE_W +: SIZE_W];
    assign beat_hs  = (state == DATA) && outbuf_valid[owner] && ami_wr_ready;

    // Next-state, next address/remaining bookkeeping and the length of the next command.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        addr_nxt  = addr;
        rem_nxt   = rem;
        beats_nxt = beats;
        case (state)
            IDLE: if (|pu_wr_req) state_nxt = ARB;
            ARB: begin
                if (arb_any) begin
                    owner_nxt = arb_idx;
                    addr_nxt  = sel_addr & ~ADDR_W'(LINE_BYTES - 1);
                    rem_nxt   = sel_size;
                    state_nxt = (sel_size == '0) ? DONE : CMD;
                end else begin
                    // requester withdrew before it could be granted
                    state_nxt = IDLE;
                end
            end
            CMD: begin
                if (ami_cmd_ready) begin
                    state_nxt = DATA;
                    beats_nxt = cmd_len;
                end
            end
            DATA: begin
                if (beat_hs) begin
                    beats_nxt = beats - LEN_W'(1);
                    if (beats == LEN_W'(1)) begin
                        addr_nxt  = addr + (ADDR_W'(cmd_len) << LINE_SHIFT);
                        rem_nxt   = rem - SIZE_W'(cmd_len);
                        state_nxt = (rem_nxt == '0) ? DONE : CMD;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // clip to what is left, to the burst cap, and to the end of the 4KB page
        len_nxt = LEN_W'(min3(32'(rem_nxt), 32'(MAX_BURST),
                              32'(PAGE_BYTES / LINE_BYTES) - 32'(addr_nxt[LINE_SHIFT +: 6])));
    end

    // State, datapath registers and registered handshake/pulse outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            addr        <= '0;
            rem         <= '0;
            beats       <= '0;
            cmd_len     <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            grant_q     <= '0;
            done_q      <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            addr        <= addr_nxt;
            rem         <= rem_nxt;
            beats       <= beats_nxt;
            cmd_valid_q <= (state_nxt == CMD);
            busy_q      <= (state_nxt != IDLE);
            grant_q     <= (state == ARB && arb_any) ? arb_gnt : '0;
            done_q      <= (state_nxt == DONE) ? (NUM_PU'(1) << owner_nxt) : '0;
            if (state_nxt == CMD && state != CMD)
                cmd_len <= len_nxt;
            if (state == ARB && arb_any)
                rr_ptr <= (arb_idx == SRC_W'(NUM_PU - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    assign pu_wr_grant   = grant_q;
    assign pu_wr_done    = done_q;
    assign busy          = busy_q;
    assign ami_cmd_valid = cmd_valid_q;
    assign ami_cmd_addr  = cmd_valid_q ? addr : '0;
    assign ami_cmd_len   = cmd_valid_q ? cmd_len : '0;
    assign ami_wr_valid  = (state == DATA) && outbuf_valid[owner];
    assign ami_wr_last   = (state == DATA) && (beats == LEN_W'(1));
    assign ami_wr_src    = (state == IDLE) ? '0 : owner;
    assign outbuf_pop    = beat_hs ? (NUM_PU'(1) << owner) : '0;

endmodule

// File: tb/tb_dnn2ami_wr_sched.sv
// tb/tb_dnn2ami_wr_sched.sv - directed self-checking bench for dnn2ami_wr_sched
module tb_dnn2ami_wr_sched;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   pu_wr_req = '0;
    logic [127:0] pu_wr_addr = '0;
    logic [63:0]  pu_wr_size = '0;
    logic [1:0]   pu_wr_grant, pu_wr_done, outbuf_pop;
    logic [1:0]   outbuf_valid;
    logic         ami_cmd_valid, ami_cmd_ready;
    logic [63:0]  ami_cmd_addr;
    logic [3:0]   ami_cmd_len;
    logic         ami_wr_valid, ami_wr_ready, ami_wr_last, busy;
    logic [0:0]   ami_wr_src;

    logic rand_en = 1'b0;
    logic cmd_ready_en = 1'b1;
    int   exp_src = 0;

    int n_vec = 0;
    int n_err = 0;

    // monitor state
    int          n_cmd = 0, n_hs = 0, n_last = 0, n_grant = 0, n_done = 0;
    int          n_pop0 = 0, n_pop1 = 0, n_pop_bad = 0, n_len_bad = 0, n_src_bad = 0, n_gbad = 0;
    int          cur_beats = 0, cur_len = 0;
    logic [63:0] cmd_addr_log [64];
    int          cmd_len_log  [64];
    int          last_at_log  [64];
    logic [1:0]  grant_log    [64];

    dnn2ami_wr_sched dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pu_wr_req     (pu_wr_req),
        .pu_wr_addr    (pu_wr_addr),
        .pu_wr_size    (pu_wr_size),
        .pu_wr_grant   (pu_wr_grant),
        .pu_wr_done    (pu_wr_done),
        .outbuf_valid  (outbuf_valid),
        .outbuf_pop    (outbuf_pop),
        .ami_cmd_valid (ami_cmd_valid),
        .ami_cmd_ready (ami_cmd_ready),
        .ami_cmd_addr  (ami_cmd_addr),
        .ami_cmd_len   (ami_cmd_len),
        .ami_wr_valid  (ami_wr_valid),
        .ami_wr_ready  (ami_wr_ready),
        .ami_wr_src    (ami_wr_src),
        .ami_wr_last   (ami_wr_last),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sink side: buffer-valid / ready / cmd_ready, either steady or randomly toggled.
    initial begin
        outbuf_valid  = 2'b11;
        ami_wr_ready  = 1'b1;
        ami_cmd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) begin
                outbuf_valid = 2'($urandom);
                ami_wr_ready = 1'($urandom_range(0, 1));
            end else begin
                outbuf_valid = 2'b11;
                ami_wr_ready = 1'b1;
            end
            ami_cmd_ready = cmd_ready_en;
        end
    end

    // Observe handshakes, pops, grants and done pulses away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            int         own;
            logic       hs;
            logic [1:0] exp_pop;
            own     = (exp_src < 0) ? int'(ami_wr_src) : exp_src;
            hs      = ami_wr_valid && ami_wr_ready;
            exp_pop = hs ? (2'b01 << own) : 2'b00;
            if (outbuf_pop !== exp_pop) n_pop_bad++;
            n_pop0 += int'(outbuf_pop[0]);
            n_pop1 += int'(outbuf_pop[1]);
            if (ami_cmd_valid && ami_cmd_ready) begin
                if (n_cmd < 64) begin
                    cmd_addr_log[n_cmd] = ami_cmd_addr;
                    cmd_len_log[n_cmd]  = int'(ami_cmd_len);
                end
                n_cmd++;
                cur_len   = int'(ami_cmd_len);
                cur_beats = 0;
            end
            if (hs) begin
                n_hs++;
                cur_beats++;
                if (exp_src >= 0 && int'(ami_wr_src) != exp_src) n_src_bad++;
                if (ami_wr_last) begin
                    if (n_last < 64) last_at_log[n_last] = n_hs;
                    n_last++;
                    if (cur_beats != cur_len) n_len_bad++;
                end
            end
            if (pu_wr_grant != 2'b00) begin
                if (n_grant < 64) grant_log[n_grant] = pu_wr_grant;
                n_grant++;
                if ($countones(pu_wr_grant) != 1) n_gbad++;
            end
            if (pu_wr_done != 2'b00) n_done++;
        end
    end

    task automatic start_req(input int pu, input logic [63:0] a, input logic [31:0] s,
                             output int lat, output logic cv);
        logic got;
        pu_wr_addr[pu*64 +: 64] = a;
        pu_wr_size[pu*32 +: 32] = s;
        @(posedge clk);
        #1;
        pu_wr_req[pu] = 1'b1;
        lat = 0;
        got = 1'b0;
        cv  = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (pu_wr_grant[pu]) begin
                got = 1'b1;
                cv  = ami_cmd_valid;
            end
        end
        chk("grant_seen", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        pu_wr_req[pu] = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (!busy) ok = 1'b1;
        end
        chk("idle_reached", 64'(ok), 64'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int   lat;
        logic cv;
        int   b_cmd, b_hs, b_last, b_grant, b_done, b_pop0, b_pop1;
        logic ok;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outs", 64'({pu_wr_grant, pu_wr_done, outbuf_pop, ami_cmd_valid,
                             ami_wr_valid, ami_wr_last, ami_wr_src}), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // PU0 0x0 size 20: three bursts, last on beats 8/16/20
        exp_src = 0;
        b_cmd = n_cmd; b_hs = n_hs; b_last = n_last; b_done = n_done; b_pop0 = n_pop0; b_pop1 = n_pop1;
        start_req(0, 64'h0, 32'd20, lat, cv);
        chk("t1_latency", 64'(lat), 64'd3);
        chk("t1_cmdv_at_grant", 64'(cv), 64'd1);
        wait_idle();
        chk("t1_ncmd", 64'(n_cmd - b_cmd), 64'd3);
        chk("t1_c0_addr", cmd_addr_log[b_cmd], 64'h000);
        chk("t1_c0_len", 64'(cmd_len_log[b_cmd]), 64'd8);
        chk("t1_c1_addr", cmd_addr_log[b_cmd+1], 64'h200);
        chk("t1_c1_len", 64'(cmd_len_log[b_cmd+1]), 64'd8);
        chk("t1_c2_addr", cmd_addr_log[b_cmd+2], 64'h400);
        chk("t1_c2_len", 64'(cmd_len_log[b_cmd+2]), 64'd4);
        chk("t1_pops0", 64'(n_pop0 - b_pop0), 64'd20);
        chk("t1_pops1", 64'(n_pop1 - b_pop1), 64'd0);
        chk("t1_nlast", 64'(n_last - b_last), 64'd3);
        chk("t1_last_a", 64'(last_at_log[b_last] - b_hs), 64'd8);
        chk("t1_last_b", 64'(last_at_log[b_last+1] - b_hs), 64'd16);
        chk("t1_last_c", 64'(last_at_log[b_last+2] - b_hs), 64'd20);
        chk("t1_done", 64'(n_done - b_done), 64'd1);

        // PU1 0xFC0 size 3: page split
        exp_src = 1;
        b_cmd = n_cmd; b_pop0 = n_pop0; b_pop1 = n_pop1; b_done = n_done;
        start_req(1, 64'hFC0, 32'd3, lat, cv);
        wait_idle();
        chk("t2_ncmd", 64'(n_cmd - b_cmd), 64'd2);
        chk("t2_c0_addr", cmd_addr_log[b_cmd], 64'hFC0);
        chk("t2_c0_len", 64'(cmd_len_log[b_cmd]), 64'd1);
        chk("t2_c1_addr", cmd_addr_log[b_cmd+1], 64'h1000);
        chk("t2_c1_len", 64'(cmd_len_log[b_cmd+1]), 64'd2);
        chk("t2_pops1", 64'(n_pop1 - b_pop1), 64'd3);
        chk("t2_pops0", 64'(n_pop0 - b_pop0), 64'd0);
        chk("t2_done", 64'(n_done - b_done), 64'd1);

        // both PUs requesting continuously after reset: alternate grants
        pulse_reset();
        exp_src = -1;
        b_grant = n_grant;
        pu_wr_addr = {64'h2000, 64'h100};
        pu_wr_size = {32'd1, 32'd1};
        pu_wr_req  = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (n_grant - b_grant >= 4) ok = 1'b1;
        end
        pu_wr_req = 2'b00;
        chk("t3_four_grants", 64'(ok), 64'd1);
        wait_idle();
        chk("t3_g0", 64'(grant_log[b_grant]), 64'd1);
        chk("t3_g1", 64'(grant_log[b_grant+1]), 64'd2);
        chk("t3_g2", 64'(grant_log[b_grant+2]), 64'd1);
        chk("t3_g3", 64'(grant_log[b_grant+3]), 64'd2);
        chk("t3_ngrant", 64'(n_grant - b_grant), 64'd4);

        // size 0: grant and done, nothing on AMI
        exp_src = 0;
        b_cmd = n_cmd; b_pop0 = n_pop0; b_done = n_done; b_grant = n_grant;
        start_req(0, 64'h1000, 32'd0, lat, cv);
        wait_idle();
        chk("t4_ncmd", 64'(n_cmd - b_cmd), 64'd0);
        chk("t4_pops", 64'(n_pop0 - b_pop0), 64'd0);
        chk("t4_done", 64'(n_done - b_done), 64'd1);
        chk("t4_grant", 64'(n_grant - b_grant), 64'd1);

        // backpressure: cmd stalled 5 cycles, then random data handshakes
        b_cmd = n_cmd; b_pop0 = n_pop0; b_hs = n_hs;
        cmd_ready_en = 1'b0;
        rand_en = 1'b1;
        start_req(0, 64'h40, 32'd10, lat, cv);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", 64'(ami_cmd_valid), 64'd1);
            chk("t5_hold_addr", ami_cmd_addr, 64'h40);
            chk("t5_hold_len", 64'(ami_cmd_len), 64'd8);
        end
        cmd_ready_en = 1'b1;
        wait_idle();
        rand_en = 1'b0;
        chk("t5_ncmd", 64'(n_cmd - b_cmd), 64'd2);
        chk("t5_c0_addr", cmd_addr_log[b_cmd], 64'h40);
        chk("t5_c0_len", 64'(cmd_len_log[b_cmd]), 64'd8);
        chk("t5_c1_addr", cmd_addr_log[b_cmd+1], 64'h240);
        chk("t5_c1_len", 64'(cmd_len_log[b_cmd+1]), 64'd2);
        chk("t5_pops", 64'(n_pop0 - b_pop0), 64'd10);
        chk("t5_hs", 64'(n_hs - b_hs), 64'd10);
        chk("pop_vs_handshake", 64'(n_pop_bad), 64'd0);
        chk("beats_per_cmd", 64'(n_len_bad), 64'd0);
        chk("src_owner", 64'(n_src_bad), 64'd0);
        chk("grant_onehot", 64'(n_gbad), 64'd0);

        // reset during beat 3 of 8
        exp_src = 0;
        b_hs = n_hs;
        start_req(0, 64'h0, 32'd8, lat, cv);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (n_hs - b_hs >= 2) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("t6_two_beats", 64'(ok), 64'd1);
        b_done = n_done;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_outs", 64'({pu_wr_grant, pu_wr_done, outbuf_pop, ami_cmd_valid,
                            ami_wr_valid, ami_wr_last, ami_wr_src}), 64'd0);
        chk("t6_cmd_addr", ami_cmd_addr, 64'd0);
        chk("t6_cmd_len", 64'(ami_cmd_len), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_done", 64'(n_done - b_done), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);

        // pointer back at 0: with both requesting, PU0 wins
        b_grant = n_grant; b_done = n_done; b_pop0 = n_pop0;
        pu_wr_addr = {64'h3000, 64'h500};
        pu_wr_size = {32'd1, 32'd1};
        pu_wr_req  = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (pu_wr_grant != 2'b00) ok = 1'b1;
        end
        chk("t6_regrant_seen", 64'(ok), 64'd1);
        chk("t6_regrant_pu0", 64'(pu_wr_grant), 64'd1);
        @(posedge clk);
        #1;
        pu_wr_req = 2'b00;
        wait_idle();
        chk("t6_done_after", 64'(n_done - b_done), 64'd1);
        chk("t6_pop_after", 64'(n_pop0 - b_pop0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
